// File: rtl/serial_addsub32_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM encoding,
// default geometry and the counter-width helper.
package serial_addsub32_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;
  localparam int NDIGITS   = WIDTH_DEF / DIGIT_DEF;

  // A single-digit configuration still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

  localparam int CNT_W = cnt_width(NDIGITS);

endpackage

// File: rtl/serial_addsub32_digit.sv
// DIGIT-bit combinational ripple slice; also exposes the carry into its MSB
// so the top can form signed overflow on the final digit.
module ripple_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out    = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub32.sv
// Digit-serial WIDTH-bit add/subtract: one DIGIT-bit slice reused LSB-first
// over WIDTH/DIGIT cycles, start/done handshake, back-to-back via start in DONE.
module serial_addsub32
  import serial_addsub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int ND = WIDTH / DIGIT;
  localparam int CW = cnt_width(ND);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_sh, b_sh;
  logic                 carry;
  logic [WIDTH-DIGIT-1:0] acc;
  logic [DIGIT-1:0]     dg_sum;
  logic                 dg_cout, dg_cmsb;
  logic                 accept;

  ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .c_in     (carry),
    .sum      (dg_sum),
    .c_out    (dg_cout),
    .c_msb_in (dg_cmsb)
  );

  assign accept = start && (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      acc      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert b once at capture, seed carry with 1.
      state <= S_RUN;
      cnt   <= '0;
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : c_in;
    end else if (state == S_RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= dg_cout;
      acc   <= {dg_sum, acc[WIDTH-DIGIT-1:DIGIT]};
      if (cnt == LAST) begin
        // Results are published only here so sum stays stable through DONE/IDLE.
        state    <= S_DONE;
        sum      <= {dg_sum, acc};
        c_out    <= dg_cout;
        overflow <= dg_cout ^ dg_cmsb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_serial_addsub32.sv
// Scoreboard bench for serial_addsub32: expected results are queued at launch
// and popped when done pulses.
module tb_serial_addsub32;

  localparam int LAT = 8;

  typedef struct packed {
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out, overflow;
  logic [31:0] sum;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  serial_addsub32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [31:0] x,
                                 input logic [31:0] y, input logic ci);
    exp_t e;
    logic [32:0] r;
    if (s) begin
      r     = {1'b0, x} + {1'b0, ~y} + 33'd1;
      e.ovf = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      r     = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      e.ovf = (x[31] == y[31]) && (r[31] != x[31]);
    end
    e.sum   = r[31:0];
    e.c_out = r[32];
    return e;
  endfunction

  // Caller must be sitting at a negedge; start is held for exactly one edge.
  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic ci);
    start = 1'b1; sub = s; a = x; b = y; c_in = ci;
    q.push_back(model(s, x, y, ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; lat = -1 when the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got done with no pending op");
      e = '0;
    end else e = q.pop_front();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h c=%b ov=%b want all 0",
               busy, done, sum, c_out, overflow);
    end
  endtask

  task automatic test_vectors();
    logic        vs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] va[5]  = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb[5]  = '{32'd1, 32'd7, 32'd5, 32'd0, 32'd1};
    logic        vc[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      launch(vs[i], va[i], vb[i], vc[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL vec%0d_busy: got %b want 1", i, busy);
      end
      wait_done(lat);
      pop_exp(e);
      checks += 4;
      if (lat !== LAT) begin
        errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      if (sum !== e.sum) begin
        errors++; $display("FAIL vec%0d_sum: got %h want %h", i, sum, e.sum);
      end
      if (c_out !== e.c_out) begin
        errors++; $display("FAIL vec%0d_cout: got %b want %b", i, c_out, e.c_out);
      end
      if (overflow !== e.ovf) begin
        errors++; $display("FAIL vec%0d_ovf: got %b want %b", i, overflow, e.ovf);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== e.sum) begin
        errors++; $display("FAIL vec%0d_hold: done=%b sum=%h want done=0 sum=%h",
                           i, done, sum, e.sum);
      end
    end
  endtask

  // Spot-check spec constants independently of the model.
  task automatic test_known();
    int   lat;
    exp_t e;
    @(negedge clk);
    launch(1'b1, 32'd5, 32'd7, 1'b0);
    wait_done(lat);
    pop_exp(e);
    checks++;
    if (sum !== 32'hFFFF_FFFE || c_out !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL sub_5_7: got %h c=%b ov=%b want fffffffe c=0 ov=0",
                         sum, c_out, overflow);
    end
    @(negedge clk);
    launch(1'b0, 32'h7FFF_FFFF, 32'd0, 1'b1);
    wait_done(lat);
    pop_exp(e);
    checks++;
    if (sum !== 32'h8000_0000 || c_out !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL add_ovf: got %h c=%b ov=%b want 80000000 c=0 ov=1",
                         sum, c_out, overflow);
    end
  endtask

  task automatic test_ignore_busy();
    int   lat, extra;
    exp_t e;
    @(negedge clk);
    launch(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    pop_exp(e);
    checks += 2;
    if (lat !== LAT - 3) begin
      errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT - 3);
    end
    if (sum !== 32'h2345_6789 || c_out !== 1'b0) begin
      errors++; $display("FAIL ignore_sum: got %h c=%b want 23456789 c=0", sum, c_out);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_single_done: got %0d extra dones want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    exp_t e;
    @(negedge clk);
    launch(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, c_out, overflow} !== 36'd0) begin
      errors++; $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h c=%b ov=%b want all 0",
                         busy, done, sum, c_out, overflow);
    end
    pop_exp(e);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d dones want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    logic [31:0] x, y;
    logic s, ci;
    @(negedge clk);
    launch(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      wait_done(lat);
      pop_exp(e);
      checks += 4;
      if (lat !== LAT) begin
        errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      if (sum !== e.sum) begin
        errors++; $display("FAIL b2b%0d_sum: got %h want %h", i, sum, e.sum);
      end
      if (c_out !== e.c_out) begin
        errors++; $display("FAIL b2b%0d_cout: got %b want %b", i, c_out, e.c_out);
      end
      if (overflow !== e.ovf) begin
        errors++; $display("FAIL b2b%0d_ovf: got %b want %b", i, overflow, e.ovf);
      end
      if (lat < 0) break;
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (i % 7 == 0) y = x;
      launch(s, x, y, ci);
    end
    wait_done(lat);
    pop_exp(e);
    checks++;
    if (lat !== LAT || sum !== e.sum) begin
      errors++; $display("FAIL b2b_last: lat=%0d sum=%h want lat=%0d sum=%h",
                         lat, sum, LAT, e.sum);
    end
  endtask

  initial begin
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_vectors();
    test_known();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
